// File: rtl/hwpe_ctrl_job_dispatcher.sv
// hwpe_ctrl_job_dispatcher: hands out job context slots to offloading cores, queues triggered jobs, sequences the engine.
// Latency: acquire response 1 cycle; accepted trigger -> start_o after 2 cycles; engine_done_i -> done_o/evt_o after 1 cycle.
// Backpressure: none; an acquire that cannot be granted is answered with ok=0, and triggers from non-owners are dropped.
//
// Ports:
//   clk_i, rst_ni (async, active-low), clear_i (sync soft clear, same effect as reset)
//   acquire_i/acquire_core_i  -> acquire_valid_o/acquire_ok_o/acquire_ctx_o (registered response)
//   trigger_i/trigger_core_i  : commit the acquired slot into the job queue
//   start_o/engine_done_i     : engine handshake; running_ctx_o is the slot being (or last) executed
//   done_o/evt_o              : completion pulse and one-hot event to the owning core
//   busy_o, nb_queued_o, full_o : queue status
module hwpe_ctrl_job_dispatcher #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_CORES   = 9,
    localparam int unsigned CTX_W    = $clog2(N_CONTEXT),
    localparam int unsigned CORE_W   = $clog2(N_CORES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              acquire_i,
    input  logic [CORE_W-1:0] acquire_core_i,
    output logic              acquire_valid_o,
    output logic              acquire_ok_o,
    output logic [CTX_W-1:0]  acquire_ctx_o,
    input  logic              trigger_i,
    input  logic [CORE_W-1:0] trigger_core_i,
    output logic              start_o,
    output logic [CTX_W-1:0]  running_ctx_o,
    output logic              busy_o,
    input  logic              engine_done_i,
    output logic [N_CORES-1:0] evt_o,
    output logic              done_o,
    output logic [CTX_W:0]    nb_queued_o,
    output logic              full_o
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_ACQUIRED, SLOT_QUEUED, SLOT_RUNNING} slot_e;
    typedef enum logic [1:0] {FSM_IDLE, FSM_START, FSM_RUN, FSM_DONE} fsm_e;

    slot_e             slot_q  [N_CONTEXT];
    slot_e             slot_d  [N_CONTEXT];
    logic [CORE_W-1:0] owner_q [N_CONTEXT];
    logic [CORE_W-1:0] owner_d [N_CONTEXT];
    logic [CTX_W-1:0]  pointer_ctx_q, pointer_ctx_d;
    logic [CTX_W-1:0]  running_ctx_q, running_ctx_d;
    fsm_e              fsm_q, fsm_d;
    logic              acq_valid_q, acq_valid_d;
    logic              acq_ok_q, acq_ok_d;
    logic [CTX_W-1:0]  acq_ctx_q, acq_ctx_d;

    logic              any_acquired;
    logic              any_queued;
    logic              any_free;
    logic [CTX_W:0]    nb_busy;
    logic              grant;
    logic              trig_ok;

    // Slot occupancy summary
    always_comb begin
        any_acquired = 1'b0;
        any_queued   = 1'b0;
        any_free     = 1'b0;
        nb_busy      = '0;
        for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            if (slot_q[CTX_W'(i)] == SLOT_ACQUIRED) any_acquired = 1'b1;
            if (slot_q[CTX_W'(i)] == SLOT_QUEUED)   any_queued   = 1'b1;
            if (slot_q[CTX_W'(i)] == SLOT_FREE)     any_free     = 1'b1;
            if (slot_q[CTX_W'(i)] == SLOT_QUEUED || slot_q[CTX_W'(i)] == SLOT_RUNNING)
                nb_busy = nb_busy + (CTX_W+1)'(1);
        end
    end

    assign grant = acquire_i && (slot_q[pointer_ctx_q] == SLOT_FREE) && !any_acquired;

    // Grants only ever land on pointer_ctx, and pointer_ctx only advances on a trigger,
    // so the single ACQUIRED slot (if any) is always the one at pointer_ctx.
    assign trig_ok = trigger_i && (slot_q[pointer_ctx_q] == SLOT_ACQUIRED)
                     && (owner_q[pointer_ctx_q] == trigger_core_i);

    always_comb begin
        slot_d        = slot_q;
        owner_d       = owner_q;
        pointer_ctx_d = pointer_ctx_q;
        running_ctx_d = running_ctx_q;
        fsm_d         = fsm_q;
        acq_valid_d   = acquire_i;
        acq_ok_d      = grant;
        acq_ctx_d     = grant ? pointer_ctx_q : '0;

        if (grant) begin
            slot_d[pointer_ctx_q]  = SLOT_ACQUIRED;
            owner_d[pointer_ctx_q] = acquire_core_i;
        end
        if (trig_ok) begin
            slot_d[pointer_ctx_q] = SLOT_QUEUED;
            pointer_ctx_d         = pointer_ctx_q + CTX_W'(1);
        end

        // The engine only touches slot[running_ctx], which is QUEUED or RUNNING here,
        // so it never collides with the acquire/trigger updates above.
        unique case (fsm_q)
            FSM_IDLE: begin
                if (slot_q[running_ctx_q] == SLOT_QUEUED) fsm_d = FSM_START;
            end
            FSM_START: begin
                slot_d[running_ctx_q] = SLOT_RUNNING;
                fsm_d                 = FSM_RUN;
            end
            FSM_RUN: begin
                if (engine_done_i) fsm_d = FSM_DONE;
            end
            FSM_DONE: begin
                slot_d[running_ctx_q] = SLOT_FREE;
                running_ctx_d         = running_ctx_q + CTX_W'(1);
                fsm_d                 = FSM_IDLE;
            end
            default: fsm_d = FSM_IDLE;
        endcase

        if (clear_i) begin
            for (int unsigned i = 0; i < N_CONTEXT; i++) begin
                slot_d[CTX_W'(i)]  = SLOT_FREE;
                owner_d[CTX_W'(i)] = '0;
            end
            pointer_ctx_d = '0;
            running_ctx_d = '0;
            fsm_d         = FSM_IDLE;
            acq_valid_d   = 1'b0;
            acq_ok_d      = 1'b0;
            acq_ctx_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_CONTEXT; i++) begin
                slot_q[CTX_W'(i)]  <= SLOT_FREE;
                owner_q[CTX_W'(i)] <= '0;
            end
            pointer_ctx_q <= '0;
            running_ctx_q <= '0;
            fsm_q         <= FSM_IDLE;
            acq_valid_q   <= 1'b0;
            acq_ok_q      <= 1'b0;
            acq_ctx_q     <= '0;
        end else begin
            slot_q        <= slot_d;
            owner_q       <= owner_d;
            pointer_ctx_q <= pointer_ctx_d;
            running_ctx_q <= running_ctx_d;
            fsm_q         <= fsm_d;
            acq_valid_q   <= acq_valid_d;
            acq_ok_q      <= acq_ok_d;
            acq_ctx_q     <= acq_ctx_d;
        end
    end

    assign acquire_valid_o = acq_valid_q;
    assign acquire_ok_o    = acq_ok_q;
    assign acquire_ctx_o   = acq_ctx_q;
    assign start_o         = (fsm_q == FSM_START);
    assign done_o          = (fsm_q == FSM_DONE);
    assign evt_o           = done_o ? (N_CORES'(1) << owner_q[running_ctx_q]) : '0;
    assign running_ctx_o   = running_ctx_q;
    assign busy_o          = (fsm_q != FSM_IDLE) || any_queued;
    assign nb_queued_o     = nb_busy;
    assign full_o          = !any_free;

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
module tb_hwpe_ctrl_job_dispatcher;
    localparam int N_CONTEXT = 2;
    localparam int N_CORES   = 9;
    localparam int CTX_W     = 1;
    localparam int CORE_W    = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni, clear_i, acquire_i, trigger_i, engine_done_i;
    logic [CORE_W-1:0] acquire_core_i, trigger_core_i;
    logic              acquire_valid_o, acquire_ok_o, start_o, busy_o, done_o, full_o;
    logic [CTX_W-1:0]  acquire_ctx_o, running_ctx_o;
    logic [N_CORES-1:0] evt_o;
    logic [CTX_W:0]    nb_queued_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_job_dispatcher #(.N_CONTEXT(N_CONTEXT), .N_CORES(N_CORES)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .acquire_i(acquire_i), .acquire_core_i(acquire_core_i),
        .acquire_valid_o(acquire_valid_o), .acquire_ok_o(acquire_ok_o), .acquire_ctx_o(acquire_ctx_o),
        .trigger_i(trigger_i), .trigger_core_i(trigger_core_i),
        .start_o(start_o), .running_ctx_o(running_ctx_o), .busy_o(busy_o),
        .engine_done_i(engine_done_i), .evt_o(evt_o), .done_o(done_o),
        .nb_queued_o(nb_queued_o), .full_o(full_o)
    );

    typedef struct {
        int a, ac, t, tc, d;                              // inputs for the cycle
        int av, ok, actx, st, dn, evt, bsy, nb, fl, rc;   // outputs expected in that cycle
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input int a, ac, t, tc, d, av, ok, actx, st, dn, evt, bsy, nb, fl, rc);
        vec_t v;
        v.a = a; v.ac = ac; v.t = t; v.tc = tc; v.d = d;
        v.av = av; v.ok = ok; v.actx = actx; v.st = st; v.dn = dn;
        v.evt = evt; v.bsy = bsy; v.nb = nb; v.fl = fl; v.rc = rc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string p, input int av, ok, actx, st, dn, evt, bsy, nb, fl, rc);
        chk({p, ".acq_valid"}, 32'(acquire_valid_o), av);
        chk({p, ".acq_ok"},    32'(acquire_ok_o),    ok);
        chk({p, ".acq_ctx"},   32'(acquire_ctx_o),   actx);
        chk({p, ".start"},     32'(start_o),         st);
        chk({p, ".done"},      32'(done_o),          dn);
        chk({p, ".evt"},       32'(evt_o),           evt);
        chk({p, ".busy"},      32'(busy_o),          bsy);
        chk({p, ".nb_queued"}, 32'(nb_queued_o),     nb);
        chk({p, ".full"},      32'(full_o),          fl);
        chk({p, ".running"},   32'(running_ctx_o),   rc);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int a, input int ac, input int t, input int tc, input int d);
        acquire_i      = (a != 0);
        acquire_core_i = CORE_W'(ac);
        trigger_i      = (t != 0);
        trigger_core_i = CORE_W'(tc);
        engine_done_i  = (d != 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        clear_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic wait_start(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (start_o) seen = 1'b1;
            else tick();
        end
    endtask

    // Reference model: triggered jobs kept in a FIFO in trigger order, engine timing
    // derived from the cycle each job was triggered and the cycle the engine went idle.
    int q_ctx[$];
    int q_own[$];
    int q_push[$];
    bit m_acq;
    int m_acq_ctx, m_acq_own, m_ptr, m_start, m_done, m_idle;
    bit e_av, e_ok;
    int e_actx;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        bit seen;
        int ndone;

        rst_ni = 1'b0;
        clear_i = 1'b0;
        drive(0, 0, 0, 0, 0);

        //            a ac t tc d | av ok actx st dn evt   bsy nb fl rc
        tbl[0]  = mk(1, 3, 0, 0, 0,  0, 0, 0,  0, 0, 0,     0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 3, 0,  1, 1, 0,  0, 0, 0,     0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,     1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0,     1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0,     1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 'h008, 1, 1, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,     0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 1, 0, 0,  1, 1, 1,  0, 0, 0,     0, 0, 0, 1);
        tbl[8]  = mk(1, 5, 0, 0, 0,  0, 0, 0,  0, 0, 0,     1, 1, 0, 1);
        tbl[9]  = mk(0, 0, 1, 5, 0,  1, 1, 0,  1, 0, 0,     1, 1, 1, 1);
        tbl[10] = mk(1, 7, 0, 0, 0,  0, 0, 0,  0, 0, 0,     1, 2, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 1,  1, 0, 0,  0, 0, 0,     1, 2, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 'h001, 1, 2, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,     1, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0,     1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0,     1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 'h020, 1, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,     0, 0, 0, 1);

        // Directed vectors: single job, then two jobs filling both slots
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].a, tbl[i].ac, tbl[i].t, tbl[i].tc, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].av, tbl[i].ok, tbl[i].actx, tbl[i].st, tbl[i].dn,
                    tbl[i].evt, tbl[i].bsy, tbl[i].nb, tbl[i].fl, tbl[i].rc);
            tick();
        end
        drive(0, 0, 0, 0, 0);

        // Trigger from a non-owner is dropped, second acquire refused while one is outstanding
        do_reset();
        drive(1, 1, 0, 0, 0); tick();
        chk("own.ok1", 32'(acquire_ok_o), 1);
        drive(1, 2, 0, 0, 0); tick();
        chk("own.valid2", 32'(acquire_valid_o), 1);
        chk("own.ok2", 32'(acquire_ok_o), 0);
        drive(0, 0, 1, 2, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("own.nb_after_bad_trig", 32'(nb_queued_o), 0);
        tick();
        chk("own.no_start", 32'(start_o), 0);
        chk("own.busy_idle", 32'(busy_o), 0);
        drive(0, 0, 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("own.nb_queued", 32'(nb_queued_o), 1);
        tick();
        chk("own.start", 32'(start_o), 1);
        tick();
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("own.done", 32'(done_o), 1);
        chk("own.evt", 32'(evt_o), 'h002);
        tick();

        // Five back-to-back jobs wrap the context pointer
        do_reset();
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1, k, 0, 0, 0); tick();
            chk($sformatf("wrap%0d.ok", k), 32'(acquire_ok_o), 1);
            chk($sformatf("wrap%0d.ctx", k), 32'(acquire_ctx_o), k % 2);
            drive(0, 0, 1, k, 0); tick();
            drive(0, 0, 0, 0, 0);
            wait_start(6, seen);
            chk($sformatf("wrap%0d.start_seen", k), 32'(seen), 1);
            chk($sformatf("wrap%0d.running", k), 32'(running_ctx_o), k % 2);
            tick();
            drive(0, 0, 0, 0, 1); tick();
            drive(0, 0, 0, 0, 0);
            chk($sformatf("wrap%0d.evt", k), 32'(evt_o), 32'(1) << k);
            if (done_o) ndone++;
            tick();
        end
        chk("wrap.done_count", ndone, 5);

        // Acquire colliding with engine completion sees the pre-DONE state
        do_reset();
        drive(1, 0, 0, 0, 0); tick();
        chk("col.ok0", 32'(acquire_ok_o), 1);
        drive(0, 0, 1, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("col.ctx1", 32'(acquire_ctx_o), 1);
        chk("col.start0", 32'(start_o), 1);
        drive(0, 0, 1, 1, 0); tick();
        chk("col.full", 32'(full_o), 1);
        chk("col.nb2", 32'(nb_queued_o), 2);
        drive(1, 2, 0, 0, 1); tick();
        chk("col.done", 32'(done_o), 1);
        chk("col.ok_at_edone", 32'(acquire_ok_o), 0);
        chk("col.valid_at_edone", 32'(acquire_valid_o), 1);
        drive(1, 2, 0, 0, 0); tick();
        chk("col.ok_at_done", 32'(acquire_ok_o), 0);
        chk("col.full_after", 32'(full_o), 0);
        tick();
        chk("col.ok_after", 32'(acquire_ok_o), 1);
        chk("col.ctx_after", 32'(acquire_ctx_o), 0);
        chk("col.start1", 32'(start_o), 1);
        drive(0, 0, 1, 2, 0); tick();
        drive(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a run
        do_reset();
        drive(1, 4, 0, 0, 0); tick();
        drive(0, 0, 1, 4, 0); tick();
        drive(0, 0, 0, 0, 0);
        wait_start(6, seen);
        chk("rst.start_seen", 32'(seen), 1);
        tick();
        chk("rst.busy_before", 32'(busy_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all("rst.mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("rst.no_done", 32'(done_o), 0);
        chk("rst.no_evt", 32'(evt_o), 0);
        tick();
        chk("rst.no_done2", 32'(done_o), 0);
        chk("rst.busy_after", 32'(busy_o), 0);

        // Synchronous clear in the middle of a run, pointer back to slot 0
        drive(1, 6, 0, 0, 0); tick();
        drive(0, 0, 1, 6, 0); tick();
        drive(0, 0, 0, 0, 0);
        wait_start(6, seen);
        chk("clr.start_seen", 32'(seen), 1);
        tick();
        clear_i = 1'b1; tick();
        clear_i = 1'b0;
        chk("clr.busy", 32'(busy_o), 0);
        chk("clr.nb", 32'(nb_queued_o), 0);
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("clr.no_done", 32'(done_o), 0);
        drive(1, 6, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("clr.ok", 32'(acquire_ok_o), 1);
        chk("clr.ctx", 32'(acquire_ctx_o), 0);

        // Randomised traffic against the job-FIFO model
        do_reset();
        q_ctx.delete(); q_own.delete(); q_push.delete();
        m_acq = 1'b0; m_acq_ctx = 0; m_acq_own = 0; m_ptr = 0;
        m_start = -1; m_done = -1; m_idle = 0;
        e_av = 1'b0; e_ok = 1'b0; e_actx = 0;
        for (int t = 0; t < 3000; t++) begin
            int a, ac, tr, tc, d, ev, rc, qn;
            bit in_q, g;
            a  = ($urandom_range(2) == 0) ? 1 : 0;
            ac = int'($urandom_range(N_CORES - 1));
            tr = ($urandom_range(2) == 0) ? 1 : 0;
            tc = (m_acq && $urandom_range(3) != 0) ? m_acq_own : int'($urandom_range(N_CORES - 1));
            d  = ($urandom_range(3) == 0) ? 1 : 0;
            drive(a, ac, tr, tc, d);

            qn = q_ctx.size();
            if (qn > 0 && m_start < 0 && t >= q_push[0] + 2 && t >= m_idle + 1) m_start = t;
            ev = (m_done == t) ? (1 << q_own[0]) : 0;
            rc = (qn > 0) ? q_ctx[0] : m_ptr;
            chk_all($sformatf("rnd%0d", t), e_av, e_ok, e_actx, (m_start == t) ? 1 : 0,
                    (m_done == t) ? 1 : 0, ev, (qn > 0) ? 1 : 0, qn,
                    (qn + int'(m_acq) == N_CONTEXT) ? 1 : 0, rc);

            in_q = 1'b0;
            foreach (q_ctx[k]) if (q_ctx[k] == m_ptr) in_q = 1'b1;
            g = (a != 0) && !m_acq && !in_q;
            e_av = (a != 0);
            e_ok = g;
            e_actx = g ? m_ptr : 0;
            if (tr != 0 && m_acq && tc == m_acq_own) begin
                q_ctx.push_back(m_acq_ctx);
                q_own.push_back(m_acq_own);
                q_push.push_back(t);
                m_acq = 1'b0;
                m_ptr = (m_ptr + 1) % N_CONTEXT;
            end
            if (g) begin
                m_acq = 1'b1;
                m_acq_ctx = m_ptr;
                m_acq_own = ac;
            end
            if (d != 0 && m_start >= 0 && m_start < t && m_done < 0) m_done = t + 1;
            if (m_done == t) begin
                void'(q_ctx.pop_front());
                void'(q_own.pop_front());
                void'(q_push.pop_front());
                m_start = -1;
                m_done = -1;
                m_idle = t + 1;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
